// File: rtl/processor_trace_buffer_pkg.sv
// Shared definitions for the processor trace buffer: trace state encodings,
// entry width and the bit offsets of each field inside rd_data.
// Optional feature macro: TRACE_TIMESTAMP_EN (prepends a cycle timestamp).
package processor_trace_buffer_pkg;

    typedef enum logic [1:0] {
        TR_IDLE  = 2'd0,
        TR_ARMED = 2'd1,
        TR_POST  = 2'd2,
        TR_DONE  = 2'd3
    } trace_state_e;

`ifdef TRACE_TIMESTAMP_EN
    localparam bit TS_EN = 1'b1;
`else
    localparam bit TS_EN = 1'b0;
`endif

    // Full entry width, including the timestamp when it is built in.
    function automatic int entry_width(input int state_w, input int pc_w,
                                       input int data_w, input int ts_w);
        return (TS_EN ? ts_w : 32'sd0) + state_w + pc_w + 32'sd3 * data_w;
    endfunction

    // Field offsets inside an entry; data sits in the LSBs.
    function automatic int off_data(input int data_w);
        return 32'sd0 * data_w;
    endfunction

    function automatic int off_operand(input int data_w);
        return data_w;
    endfunction

    function automatic int off_opcode(input int data_w);
        return 32'sd2 * data_w;
    endfunction

    function automatic int off_pc(input int data_w);
        return 32'sd3 * data_w;
    endfunction

    function automatic int off_state(input int data_w, input int pc_w);
        return 32'sd3 * data_w + pc_w;
    endfunction

    function automatic int off_ts(input int data_w, input int pc_w, input int state_w);
        return 32'sd3 * data_w + pc_w + state_w;
    endfunction

endpackage

// File: rtl/processor_trace_buffer_ram.sv
// Trace storage: DEPTH x WIDTH simple dual-port array with synchronous write.
// The read port is combinational here; the read register sits in the top so
// that rd_data can be cleared by reset while the array itself is never reset.
module processor_trace_buffer_ram #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 67,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Write port: store one trace entry per capture.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/processor_trace_buffer.sv
// Processor trace buffer: captures {[ts,] state, pc, opcode, operand, data}
// into a circular buffer around a PC-match trigger, then replays the stored
// window oldest-first over a valid/ready port.
// Optional feature macro: TRACE_TIMESTAMP_EN (free-running cycle timestamp
// prepended to every entry; the change filter ignores it).
module processor_trace_buffer
    import processor_trace_buffer_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int PC_W      = 16,
    parameter int STATE_W   = 3,
    parameter int DEPTH     = 64,
    parameter int POST_TRIG = 16,
    parameter int TS_W      = 16,
    localparam int ENTRY_W  = entry_width(STATE_W, PC_W, DATA_W, TS_W),
    localparam int CNT_W    = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [PC_W-1:0]    pc_in,
    input  logic [STATE_W-1:0] state_in,
    input  logic [DATA_W-1:0]  opcode_in,
    input  logic [DATA_W-1:0]  operand_in,
    input  logic [DATA_W-1:0]  data_in,
    input  logic               arm,
    input  logic               cap_all,
    input  logic               trig_en,
    input  logic [PC_W-1:0]    trig_pc,
    input  logic               trig_force,
    input  logic               rd_ready,
    output logic               rd_valid,
    output logic [ENTRY_W-1:0] rd_data,
    output logic [1:0]         trace_state,
    output logic [CNT_W-1:0]   trace_count,
    output logic               trace_done
);

    localparam int AW     = $clog2(DEPTH);
    localparam int BASE_W = STATE_W + PC_W + 3 * DATA_W;

    localparam logic [AW-1:0]    ZERO_PTR = {AW{1'b0}};
    localparam logic [AW-1:0]    ONE_PTR  = AW'(1);
    localparam logic [AW-1:0]    LAST_PTR = AW'(DEPTH - 1);
    localparam logic [CNT_W-1:0] ZERO_C   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] POST_C   = CNT_W'(POST_TRIG);

    trace_state_e        state_r;
    logic [AW-1:0]       wr_ptr_r;
    logic [AW-1:0]       rd_ptr_r;
    logic [CNT_W-1:0]    count_r;
    logic [CNT_W-1:0]    post_cnt_r;
    logic [CNT_W-1:0]    remaining_r;
    logic                wrapped_r;
    logic                first_r;
    logic [BASE_W-1:0]   last_r;
    logic                rd_valid_r;
    logic [ENTRY_W-1:0]  rd_data_r;
    logic                trace_done_r;

    logic [BASE_W-1:0]   fields_s;
    logic [ENTRY_W-1:0]  entry_s;
    logic [ENTRY_W-1:0]  ram_rd_s;
    logic                active_s;
    logic                hit_s;
    logic                cap_s;
    logic                wrap_now_s;
    logic [AW-1:0]       wr_ptr_nxt_s;
    logic                wrapped_nxt_s;
    logic [CNT_W-1:0]    count_nxt_s;
    logic                xfer_s;
    logic                load_s;

    assign fields_s = {state_in, pc_in, opcode_in, operand_in, data_in};

`ifdef TRACE_TIMESTAMP_EN
    logic [TS_W-1:0] ts_r;

    // Free-running cycle timestamp, wraps, counts in every trace state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ts_r <= {TS_W{1'b0}};
        end else begin
            ts_r <= ts_r + TS_W'(1);
        end
    end

    assign entry_s = {ts_r, fields_s};
`else
    assign entry_s = fields_s;
`endif

    processor_trace_buffer_ram #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (cap_s),
        .wr_addr (wr_ptr_r),
        .wr_data (entry_s),
        .rd_addr (rd_ptr_r),
        .rd_data (ram_rd_s)
    );

    // Capture decision, pointer/count next values and readout handshake.
    always_comb begin
        active_s      = (state_r == TR_ARMED) || (state_r == TR_POST);
        hit_s         = (state_r == TR_ARMED) &&
                        (trig_force || (trig_en && (pc_in == trig_pc)));
        cap_s         = active_s &&
                        (cap_all || first_r || (fields_s != last_r) || hit_s);
        wrap_now_s    = (wr_ptr_r == LAST_PTR);
        wr_ptr_nxt_s  = wr_ptr_r + ONE_PTR;
        wrapped_nxt_s = wrapped_r || wrap_now_s;
        count_nxt_s   = (count_r == DEPTH_C) ? count_r : (count_r + ONE_C);
        xfer_s        = rd_valid_r && rd_ready;
        load_s        = (state_r == TR_DONE) && (remaining_r != ZERO_C) &&
                        (!rd_valid_r || rd_ready);
    end

    // Trace FSM: arming, capture, trigger/post-trigger countdown and readout.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= TR_IDLE;
            wr_ptr_r     <= ZERO_PTR;
            rd_ptr_r     <= ZERO_PTR;
            count_r      <= ZERO_C;
            post_cnt_r   <= ZERO_C;
            remaining_r  <= ZERO_C;
            wrapped_r    <= 1'b0;
            first_r      <= 1'b0;
            last_r       <= {BASE_W{1'b0}};
            rd_valid_r   <= 1'b0;
            rd_data_r    <= {ENTRY_W{1'b0}};
            trace_done_r <= 1'b0;
        end else begin
            case (state_r)
                TR_IDLE, TR_DONE: begin
                    if (arm) begin
                        // Arm restarts capture and aborts any readout.
                        state_r      <= TR_ARMED;
                        wr_ptr_r     <= ZERO_PTR;
                        rd_ptr_r     <= ZERO_PTR;
                        count_r      <= ZERO_C;
                        post_cnt_r   <= ZERO_C;
                        remaining_r  <= ZERO_C;
                        wrapped_r    <= 1'b0;
                        first_r      <= 1'b1;
                        rd_valid_r   <= 1'b0;
                        trace_done_r <= 1'b0;
                    end else if (state_r == TR_DONE) begin
                        // Prefetch the next entry whenever the output slot frees.
                        if (load_s) begin
                            rd_data_r   <= ram_rd_s;
                            rd_valid_r  <= 1'b1;
                            rd_ptr_r    <= rd_ptr_r + ONE_PTR;
                            remaining_r <= remaining_r - ONE_C;
                        end else if (xfer_s) begin
                            rd_valid_r  <= 1'b0;
                        end
                        if ((remaining_r == ZERO_C) && (!rd_valid_r || xfer_s)) begin
                            trace_done_r <= 1'b1;
                        end
                    end
                end
                TR_ARMED, TR_POST: begin
                    if (cap_s) begin
                        wr_ptr_r  <= wr_ptr_nxt_s;
                        wrapped_r <= wrapped_nxt_s;
                        count_r   <= count_nxt_s;
                        last_r    <= fields_s;
                        first_r   <= 1'b0;
                        if (hit_s) begin
                            post_cnt_r <= POST_C;
                            if (POST_TRIG == 0) begin
                                state_r     <= TR_DONE;
                                rd_ptr_r    <= wrapped_nxt_s ? wr_ptr_nxt_s : ZERO_PTR;
                                remaining_r <= count_nxt_s;
                            end else begin
                                state_r     <= TR_POST;
                            end
                        end else if (state_r == TR_POST) begin
                            post_cnt_r <= post_cnt_r - ONE_C;
                            if (post_cnt_r == ONE_C) begin
                                // Oldest entry is the slot after the newest once wrapped.
                                state_r     <= TR_DONE;
                                rd_ptr_r    <= wrapped_nxt_s ? wr_ptr_nxt_s : ZERO_PTR;
                                remaining_r <= count_nxt_s;
                            end
                        end
                    end
                end
                default: begin
                    state_r <= TR_IDLE;
                end
            endcase
        end
    end

    assign rd_valid    = rd_valid_r;
    assign rd_data     = rd_data_r;
    assign trace_state = state_r;
    assign trace_count = count_r;
    assign trace_done  = trace_done_r;

endmodule

// File: tb/tb_processor_trace_buffer.sv
// Self-checking bench for processor_trace_buffer. A queue-based model of the
// capture window and the readout stream is checked against the DUT on every
// falling clock edge; directed scenarios add literal expectations.
module tb_processor_trace_buffer;
    import processor_trace_buffer_pkg::*;

    localparam int DATA_W    = 16;
    localparam int PC_W      = 16;
    localparam int STATE_W   = 3;
    localparam int DEPTH     = 64;
    localparam int POST_TRIG = 4;
    localparam int TS_W      = 16;
    localparam int ENTRY_W   = entry_width(STATE_W, PC_W, DATA_W, TS_W);
    localparam int CNT_W     = $clog2(DEPTH) + 1;
    localparam int BASE_W    = STATE_W + PC_W + 3 * DATA_W;
    localparam int OFF_PC    = off_pc(DATA_W);
    localparam int OFF_DATA  = off_data(DATA_W);
    localparam int OFF_TS    = off_ts(DATA_W, PC_W, STATE_W);

    logic               clk;
    logic               reset;
    logic [PC_W-1:0]    pc_in;
    logic [STATE_W-1:0] state_in;
    logic [DATA_W-1:0]  opcode_in;
    logic [DATA_W-1:0]  operand_in;
    logic [DATA_W-1:0]  data_in;
    logic               arm;
    logic               cap_all;
    logic               trig_en;
    logic [PC_W-1:0]    trig_pc;
    logic               trig_force;
    logic               rd_ready;
    logic               rd_valid;
    logic [ENTRY_W-1:0] rd_data;
    logic [1:0]         trace_state;
    logic [CNT_W-1:0]   trace_count;
    logic               trace_done;

    processor_trace_buffer #(
        .DATA_W(DATA_W), .PC_W(PC_W), .STATE_W(STATE_W),
        .DEPTH(DEPTH), .POST_TRIG(POST_TRIG), .TS_W(TS_W)
    ) dut (
        .clk(clk), .reset(reset), .pc_in(pc_in), .state_in(state_in),
        .opcode_in(opcode_in), .operand_in(operand_in), .data_in(data_in),
        .arm(arm), .cap_all(cap_all), .trig_en(trig_en), .trig_pc(trig_pc),
        .trig_force(trig_force), .rd_ready(rd_ready), .rd_valid(rd_valid),
        .rd_data(rd_data), .trace_state(trace_state), .trace_count(trace_count),
        .trace_done(trace_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [PC_W-1:0] pc_of(input logic [ENTRY_W-1:0] e);
        return e[OFF_PC +: PC_W];
    endfunction

    function automatic logic [DATA_W-1:0] data_of(input logic [ENTRY_W-1:0] e);
        return e[OFF_DATA +: DATA_W];
    endfunction

    // Model state: captured window, expected readout stream, observed readout.
    int                 m_state;
    logic [ENTRY_W-1:0] m_buf[$];
    logic [ENTRY_W-1:0] m_exp[$];
    logic [ENTRY_W-1:0] got_q[$];
    logic [BASE_W-1:0]  m_last;
    bit                 m_first, m_done, m_valid, stall_prev;
    int                 m_post;
    logic [TS_W-1:0]    m_ts;
    logic [ENTRY_W-1:0] held;

    function automatic logic [PC_W-1:0] q_pc(input int k);
        if (k >= 0 && k < got_q.size()) return pc_of(got_q[k]);
        return {PC_W{1'b1}};
    endfunction

    // Compare DUT against the model, then advance the model for the next edge.
    always @(negedge clk) begin : model_check
        logic [BASE_W-1:0]  f;
        logic [ENTRY_W-1:0] e;
        bit                 hit;
        if (!reset) begin
            check("rst_rd_valid", rd_valid, 0);
            check("rst_rd_data", rd_data, 0);
            check("rst_state", trace_state, 0);
            check("rst_count", trace_count, 0);
            check("rst_done", trace_done, 0);
            m_state = 0; m_buf.delete(); m_exp.delete();
            m_first = 0; m_done = 0; m_valid = 0; m_post = 0;
            m_ts = '0; stall_prev = 0; m_last = '0;
        end else begin
            check("state", trace_state, m_state);
            check("count", trace_count, m_buf.size());
            check("done", trace_done, m_done);
            check("rd_valid", rd_valid, m_valid);
            if (m_valid) check("rd_data", rd_data, m_exp[0]);
            if (stall_prev) begin
                check("stall_valid", rd_valid, 1);
                check("stall_data", rd_data, held);
            end
            stall_prev = rd_valid && !rd_ready && !arm;
            held = rd_data;

            f = {state_in, pc_in, opcode_in, operand_in, data_in};
`ifdef TRACE_TIMESTAMP_EN
            e = {m_ts, f};
`else
            e = f;
`endif
            if ((m_state == 0 || m_state == 3) && arm) begin
                m_state = 1; m_buf.delete(); m_exp.delete();
                m_first = 1; m_done = 0; m_valid = 0;
            end else if (m_state == 3) begin
                if (m_valid && rd_ready) begin
                    got_q.push_back(rd_data);
                    void'(m_exp.pop_front());
                    if (m_exp.size() == 0) m_done = 1;
                end
                m_valid = (m_exp.size() > 0);
            end else if (m_state == 1 || m_state == 2) begin
                hit = (m_state == 1) && (trig_force || (trig_en && pc_in == trig_pc));
                if (cap_all || m_first || f != m_last || hit) begin
                    m_buf.push_back(e);
                    if (m_buf.size() > DEPTH) void'(m_buf.pop_front());
                    m_last = f; m_first = 0;
                    if (hit) begin
                        m_post = POST_TRIG;
                        if (m_post == 0) begin m_state = 3; m_exp = m_buf; m_valid = 0; end
                        else m_state = 2;
                    end else if (m_state == 2) begin
                        m_post--;
                        if (m_post == 0) begin m_state = 3; m_exp = m_buf; m_valid = 0; end
                    end
                end
            end
            m_ts = m_ts + 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_fields(input int v);
        pc_in      = PC_W'(v);
        state_in   = STATE_W'(v);
        opcode_in  = 16'hA500 ^ DATA_W'(v);
        operand_in = DATA_W'(v * 3);
        data_in    = ~DATA_W'(v);
    endtask

    // Arm, then ramp the PC from base until DONE; optional forced trigger at step force_at.
    task automatic ramp(input int base, input int force_at);
        got_q.delete();
        arm = 1'b1; tick(); arm = 1'b0;
        for (int i = 0; i < 400 && trace_state != 2'd3; i++) begin
            drive_fields(base + i);
            trig_force = (i == force_at);
            tick();
        end
        trig_force = 1'b0;
        check("ramp_reached_done", trace_state, 3);
    endtask

    task automatic wait_done(input bit rand_ready);
        for (int i = 0; i < 2000 && !trace_done; i++) begin
            if (rand_ready) rd_ready = 1'($urandom_range(0, 1));
            tick();
        end
        rd_ready = 1'b1;
        check("done_reached", trace_done, 1);
    endtask

    task automatic check_ascending(input string name, input int first_pc);
        int errs = 0;
        for (int k = 0; k < got_q.size(); k++) begin
            if (pc_of(got_q[k]) != PC_W'(first_pc + k)) errs++;
        end
        check(name, errs, 0);
    endtask

    task automatic check_ts(input string name);
`ifdef TRACE_TIMESTAMP_EN
        int errs = 0;
        for (int k = 1; k < got_q.size(); k++) begin
            if (got_q[k][OFF_TS +: TS_W] != got_q[k-1][OFF_TS +: TS_W] + TS_W'(1)) errs++;
        end
        check(name, errs, 0);
`endif
    endtask

    initial begin
        reset = 1'b0; arm = 1'b0; cap_all = 1'b0; trig_en = 1'b0;
        trig_pc = '0; trig_force = 1'b0; rd_ready = 1'b1;
        drive_fields(0);
        repeat (3) tick();
        check("init_state", trace_state, 0);
        check("init_valid", rd_valid, 0);
        reset = 1'b1;
        tick();

        // 1: PC ramp, trigger at 0x0010, four post-trigger entries.
        cap_all = 1'b1; trig_en = 1'b1; trig_pc = 16'h0010;
        ramp(0, -1);
        check("t1_count", trace_count, 21);
        wait_done(1'b0);
        check("t1_len", got_q.size(), 21);
        check("t1_first_pc", q_pc(0), 16'h0000);
        check("t1_last_pc", q_pc(20), 16'h0014);
        check_ascending("t1_order", 0);
        check_ts("t1_ts_step");

        // 2: long run before the hit, buffer wraps and saturates.
        trig_pc = 16'h00C8;
        ramp(0, -1);
        check("t2_count", trace_count, 64);
        wait_done(1'b0);
        check("t2_len", got_q.size(), 64);
        check("t2_first_pc", q_pc(0), 16'h008D);
        check_ascending("t2_order", 141);

        // 3: change-only capture.
        got_q.delete();
        cap_all = 1'b0; trig_en = 1'b0;
        pc_in = 16'h0100; state_in = 3'd2; opcode_in = 16'h1234;
        operand_in = 16'h5678; data_in = 16'h9ABC;
        arm = 1'b1; tick(); arm = 1'b0;
        repeat (10) tick();
        data_in = 16'h9ABD;
        repeat (3) tick();
        check("t3_pre_trig_count", trace_count, 2);
        trig_force = 1'b1; tick(); trig_force = 1'b0;
        check("t3_trig_count", trace_count, 3);
        check("t3_post_state", trace_state, 2);
        for (int k = 0; k < 4; k++) begin
            data_in = DATA_W'(k + 1);
            tick();
        end
        wait_done(1'b0);
        check("t3_len", got_q.size(), 7);
        check("t3_changed_data", (got_q.size() > 2) ? data_of(got_q[1]) : 16'h0000, 16'h9ABD);

        // 4: random back-pressure on the readout.
        cap_all = 1'b1; trig_en = 1'b1; trig_pc = 16'h0030;
        ramp(0, -1);
        wait_done(1'b1);
        check("t4_len", got_q.size(), 53);
        check_ascending("t4_order", 0);
        check_ts("t4_ts_step");

        // 5a: reset in the middle of POST.
        got_q.delete();
        trig_pc = 16'h0008;
        arm = 1'b1; tick(); arm = 1'b0;
        for (int i = 0; i < 100 && trace_state != 2'd2; i++) begin
            drive_fields(i); tick();
        end
        drive_fields(100); tick();
        check("t5a_in_post", trace_state, 2);
        reset = 1'b0; #1;
        check("t5a_async_state", trace_state, 0);
        check("t5a_async_count", trace_count, 0);
        tick(); reset = 1'b1; tick();

        // 5b: reset in the middle of a stalled readout.
        trig_en = 1'b0; rd_ready = 1'b0;
        ramp(16'h0100, 3);
        for (int i = 0; i < 20 && !rd_valid; i++) tick();
        tick();
        check("t5b_valid_stalled", rd_valid, 1);
        check("t5b_first_pc", pc_of(rd_data), 16'h0100);
        reset = 1'b0; #1;
        check("t5b_async_valid", rd_valid, 0);
        check("t5b_async_data", rd_data, 0);
        check("t5b_async_state", trace_state, 0);
        tick(); reset = 1'b1; rd_ready = 1'b1; tick();

        // Re-arm after reset.
        trig_en = 1'b1; trig_pc = 16'h0010;
        ramp(0, -1);
        wait_done(1'b0);
        check("t5_rearm_len", got_q.size(), 21);
        check("t5_rearm_last_pc", q_pc(20), 16'h0014);

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
